// File: rtl/axi_read_arbiter_2to1_if.sv
// AXI read-channel bundle (AR + R) shared by both upstream masters and the RAM side.
interface axi_read_arbiter_2to1_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int ID_W   = 8
);
    logic [ADDR_W-1:0] ar_addr;
    logic [1:0]        ar_burst;
    logic [2:0]        ar_size;
    logic [ID_W-1:0]   ar_id;
    logic [7:0]        ar_len;
    logic              ar_valid;
    logic              ar_ready;
    logic [DATA_W-1:0] r_data;
    logic [ID_W-1:0]   r_id;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_valid;
    logic              r_ready;

    modport master (
        output ar_addr, ar_burst, ar_size, ar_id, ar_len, ar_valid,
        input  ar_ready,
        input  r_data, r_id, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  ar_addr, ar_burst, ar_size, ar_id, ar_len, ar_valid,
        output ar_ready,
        output r_data, r_id, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_read_arbiter_2to1.sv
// Round-robin 2:1 AXI read arbiter: one burst outstanding, registered AR toward the RAM,
// combinational R routing to the granted master until the RLAST handshake.
module axi_read_arbiter_2to1 #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 8
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset,
    axi_read_arbiter_2to1_if.slave  s0,
    axi_read_arbiter_2to1_if.slave  s1,
    axi_read_arbiter_2to1_if.master m
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_sel;
    logic                      r_prio;
    logic                      r_ar_valid;
    logic [AXI_ADDR_WIDTH-1:0] r_ar_addr;
    logic [1:0]                r_ar_burst;
    logic [2:0]                r_ar_size;
    logic [AXI_ID_WIDTH-1:0]   r_ar_id;
    logic [7:0]                r_ar_len;

    logic                      w_grant;
    logic                      w_grant_sel;
    logic                      w_last_hs;
    logic                      w_s0_ar_ready;
    logic                      w_s1_ar_ready;
    logic                      w_s0_r_valid;
    logic                      w_s1_r_valid;
    logic                      w_m_r_ready;
    logic [AXI_DATA_WIDTH-1:0] w_r_data;
    logic [AXI_ID_WIDTH-1:0]   w_r_id;

    // Next-state, grant and handshake decode; reset forces every ready/valid low.
    always_comb begin
        w_next_state  = r_state;
        w_grant       = 1'b0;
        w_grant_sel   = r_sel;
        w_last_hs     = 1'b0;
        w_s0_ar_ready = 1'b0;
        w_s1_ar_ready = 1'b0;
        w_s0_r_valid  = 1'b0;
        w_s1_r_valid  = 1'b0;
        w_m_r_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!axi_reset && (s0.ar_valid || s1.ar_valid)) begin
                    w_grant       = 1'b1;
                    w_grant_sel   = (s0.ar_valid && s1.ar_valid) ? r_prio : s1.ar_valid;
                    w_s0_ar_ready = ~w_grant_sel;
                    w_s1_ar_ready = w_grant_sel;
                    w_next_state  = ST_ADDR;
                end else begin
                    w_next_state  = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (r_ar_valid && m.ar_ready) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (!axi_reset) begin
                    w_m_r_ready  = r_sel ? s1.r_ready : s0.r_ready;
                    w_s0_r_valid = ~r_sel & m.r_valid;
                    w_s1_r_valid = r_sel & m.r_valid;
                end else begin
                    w_m_r_ready  = 1'b0;
                end
                if (m.r_valid && w_m_r_ready && m.r_last) begin
                    w_last_hs    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and the registered downstream AR channel.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_prio     <= 1'b0;
            r_ar_valid <= 1'b0;
            r_ar_addr  <= {AXI_ADDR_WIDTH{1'b0}};
            r_ar_burst <= 2'd0;
            r_ar_size  <= 3'd0;
            r_ar_id    <= {AXI_ID_WIDTH{1'b0}};
            r_ar_len   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_sel      <= w_grant_sel;
                r_ar_valid <= 1'b1;
                r_ar_addr  <= w_grant_sel ? s1.ar_addr  : s0.ar_addr;
                r_ar_burst <= w_grant_sel ? s1.ar_burst : s0.ar_burst;
                r_ar_size  <= w_grant_sel ? s1.ar_size  : s0.ar_size;
                r_ar_id    <= w_grant_sel ? s1.ar_id    : s0.ar_id;
                r_ar_len   <= w_grant_sel ? s1.ar_len   : s0.ar_len;
            end else if (r_ar_valid && m.ar_ready) begin
                r_ar_valid <= 1'b0;
            end
            // The loser of this burst is favoured on the next tie.
            if (w_last_hs) begin
                r_prio <= ~r_sel;
            end
        end
    end

    assign w_r_data    = m.r_data;
    assign w_r_id      = m.r_id;

    assign s0.ar_ready = w_s0_ar_ready;
    assign s1.ar_ready = w_s1_ar_ready;
    assign s0.r_data   = w_r_data;
    assign s1.r_data   = w_r_data;
    assign s0.r_id     = w_r_id;
    assign s1.r_id     = w_r_id;
    assign s0.r_resp   = m.r_resp;
    assign s1.r_resp   = m.r_resp;
    assign s0.r_last   = m.r_last;
    assign s1.r_last   = m.r_last;
    assign s0.r_valid  = w_s0_r_valid;
    assign s1.r_valid  = w_s1_r_valid;

    assign m.ar_addr   = r_ar_addr;
    assign m.ar_burst  = r_ar_burst;
    assign m.ar_size   = r_ar_size;
    assign m.ar_id     = r_ar_id;
    assign m.ar_len    = r_ar_len;
    assign m.ar_valid  = r_ar_valid;
    assign m.r_ready   = w_m_r_ready;
endmodule

// File: tb/tb_axi_read_arbiter_2to1.sv
// Directed bench for axi_read_arbiter_2to1: inputs driven and outputs checked on the falling edge.
module tb_axi_read_arbiter_2to1;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int IW = 8;

    logic axi_clk = 1'b0;
    logic axi_reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc;

    axi_read_arbiter_2to1_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) s0_if ();
    axi_read_arbiter_2to1_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) s1_if ();
    axi_read_arbiter_2to1_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) m_if ();

    axi_read_arbiter_2to1 #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH  (IW)
    ) dut (
        .axi_clk  (axi_clk),
        .axi_reset(axi_reset),
        .s0       (s0_if),
        .s1       (s1_if),
        .m        (m_if)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge axi_clk);
        @(negedge axi_clk);
    endtask

    task automatic set_ar(input int n, input logic v, input logic [11:0] addr,
                          input logic [7:0] len, input logic [7:0] id);
        if (n == 0) begin
            s0_if.ar_valid = v; s0_if.ar_addr = addr; s0_if.ar_len = len;
            s0_if.ar_id = id;   s0_if.ar_burst = 2'b01; s0_if.ar_size = 3'd3;
        end else begin
            s1_if.ar_valid = v; s1_if.ar_addr = addr; s1_if.ar_len = len;
            s1_if.ar_id = id;   s1_if.ar_burst = 2'b01; s1_if.ar_size = 3'd3;
        end
    endtask

    task automatic set_beat(input logic v, input logic [63:0] data, input logic [7:0] id,
                            input logic last);
        m_if.r_valid = v; m_if.r_data = data; m_if.r_id = id; m_if.r_last = last;
        m_if.r_resp = 2'b00;
    endtask

    // Lone request from master n: grant, then downstream AR handshake; ends in DATA.
    task automatic start(input int n, input logic [11:0] addr, input logic [7:0] len,
                         input logic [7:0] id);
        set_ar(n, 1'b1, addr, len, id);
        #1;
        check("grant_s0_ready", {63'd0, s0_if.ar_ready}, (n == 0) ? 64'd1 : 64'd0);
        check("grant_s1_ready", {63'd0, s1_if.ar_ready}, (n == 1) ? 64'd1 : 64'd0);
        step();
        set_ar(n, 1'b0, 12'h000, 8'd0, 8'd0);
        m_if.ar_ready = 1'b1;
        #1;
        check("ar_valid",  {63'd0, m_if.ar_valid}, 64'd1);
        check("ar_addr",   {52'd0, m_if.ar_addr},  {52'd0, addr});
        check("ar_len",    {56'd0, m_if.ar_len},   {56'd0, len});
        check("ar_id",     {56'd0, m_if.ar_id},    {56'd0, id});
        check("ar_burst",  {62'd0, m_if.ar_burst}, 64'd1);
        check("ar_size",   {61'd0, m_if.ar_size},  64'd3);
        step();
        m_if.ar_ready = 1'b0;
    endtask

    initial begin
        axi_reset = 1'b1;
        set_ar(0, 1'b1, 12'h000, 8'd0, 8'd0);
        set_ar(1, 1'b0, 12'h000, 8'd0, 8'd0);
        set_beat(1'b0, 64'd0, 8'd0, 1'b0);
        m_if.ar_ready = 1'b0;
        s0_if.r_ready = 1'b0;
        s1_if.r_ready = 1'b0;

        // Reset state.
        @(negedge axi_clk);
        #1;
        check("rst_ar_ready_forced", {63'd0, s0_if.ar_ready}, 64'd0);
        step();
        axi_reset = 1'b0;
        s0_if.ar_valid = 1'b0;
        #1;
        check("rst_m_ar_valid", {63'd0, m_if.ar_valid}, 64'd0);
        check("rst_m_ar_addr",  {52'd0, m_if.ar_addr},  64'd0);
        check("rst_m_r_ready",  {63'd0, m_if.r_ready},  64'd0);
        check("rst_s0_ar_ready", {63'd0, s0_if.ar_ready}, 64'd0);

        // Single burst, 4 beats to s0.
        start(0, 12'h040, 8'd3, 8'h11);
        s0_if.r_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            set_beat(1'b1, 64'hD000 + 64'(b), 8'h11, (b == 3));
            #1;
            check("t1_s0_r_valid", {63'd0, s0_if.r_valid}, 64'd1);
            check("t1_s1_r_valid", {63'd0, s1_if.r_valid}, 64'd0);
            check("t1_s0_r_data",  s0_if.r_data, 64'hD000 + 64'(b));
            check("t1_s0_r_id",    {56'd0, s0_if.r_id}, 64'h11);
            check("t1_s0_r_last",  {63'd0, s0_if.r_last}, (b == 3) ? 64'd1 : 64'd0);
            check("t1_m_r_ready",  {63'd0, m_if.r_ready}, 64'd1);
            step();
        end
        set_beat(1'b1, 64'hDEAD, 8'h11, 1'b0);
        #1;
        check("t1_stall_r_ready", {63'd0, m_if.r_ready},  64'd0);
        check("t1_stall_r_valid", {63'd0, s0_if.r_valid}, 64'd0);
        check("t1_idle_ar_valid", {63'd0, m_if.ar_valid}, 64'd0);
        set_beat(1'b0, 64'd0, 8'd0, 1'b0);

        // Contention from reset: grants alternate s0, s1, s0, s1.
        axi_reset = 1'b1;
        step();
        axi_reset = 1'b0;
        set_ar(0, 1'b1, 12'h0A0, 8'd0, 8'hA0);
        set_ar(1, 1'b1, 12'h0B0, 8'd0, 8'hB0);
        s1_if.r_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_s0_grant", {63'd0, s0_if.ar_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
            check("t2_s1_grant", {63'd0, s1_if.ar_ready}, (k % 2 == 1) ? 64'd1 : 64'd0);
            step();
            m_if.ar_ready = 1'b1;
            #1;
            check("t2_ar_id", {56'd0, m_if.ar_id}, (k % 2 == 0) ? 64'hA0 : 64'hB0);
            step();
            m_if.ar_ready = 1'b0;
            set_beat(1'b1, 64'(k), (k % 2 == 0) ? 8'hA0 : 8'hB0, 1'b1);
            #1;
            check("t2_s0_r_valid", {63'd0, s0_if.r_valid}, (k % 2 == 0) ? 64'd1 : 64'd0);
            check("t2_s1_r_valid", {63'd0, s1_if.r_valid}, (k % 2 == 1) ? 64'd1 : 64'd0);
            step();
            set_beat(1'b0, 64'd0, 8'd0, 1'b0);
        end
        set_ar(0, 1'b0, 12'h000, 8'd0, 8'd0);
        set_ar(1, 1'b0, 12'h000, 8'd0, 8'd0);

        // Backpressure: s1 len=7, ready toggling every cycle.
        start(1, 12'h080, 8'd7, 8'h3C);
        n_acc = 0;
        for (int c = 0; c < 16; c++) begin
            s1_if.r_ready = (c % 2 == 1);
            set_beat(1'b1, 64'h100 + 64'(c / 2), 8'h3C, (c / 2 == 7));
            #1;
            check("t3_m_r_ready", {63'd0, m_if.r_ready}, (c % 2 == 1) ? 64'd1 : 64'd0);
            check("t3_s1_r_data", s1_if.r_data, 64'h100 + 64'(c / 2));
            if (m_if.r_ready && m_if.r_valid) n_acc++;
            step();
        end
        s1_if.r_ready = 1'b1;
        #1;
        check("t3_beats_accepted", 64'(n_acc), 64'd8);
        check("t3_done_r_ready", {63'd0, m_if.r_ready}, 64'd0);
        set_beat(1'b0, 64'd0, 8'd0, 1'b0);

        // AR stall: RAM not ready for 5 cycles; s1 keeps requesting.
        set_ar(0, 1'b1, 12'h123, 8'd2, 8'h55);
        set_ar(1, 1'b1, 12'h200, 8'd0, 8'h99);
        #1;
        check("t4_s0_grant", {63'd0, s0_if.ar_ready}, 64'd1);
        step();
        set_ar(0, 1'b0, 12'hFFF, 8'd9, 8'hEE);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_stall_ar_valid", {63'd0, m_if.ar_valid}, 64'd1);
            check("t4_stall_ar_addr",  {52'd0, m_if.ar_addr},  64'h123);
            check("t4_stall_ar_id",    {56'd0, m_if.ar_id},    64'h55);
            check("t4_stall_s1_ready", {63'd0, s1_if.ar_ready}, 64'd0);
            step();
        end
        m_if.ar_ready = 1'b1;
        step();
        m_if.ar_ready = 1'b0;
        s0_if.r_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            set_beat(1'b1, 64'h200 + 64'(b), 8'h55, (b == 2));
            #1;
            check("t4_data_s1_ready", {63'd0, s1_if.ar_ready}, 64'd0);
            check("t4_data_s0_valid", {63'd0, s0_if.r_valid},  64'd1);
            step();
        end
        set_ar(1, 1'b0, 12'h000, 8'd0, 8'd0);
        set_beat(1'b0, 64'd0, 8'd0, 1'b0);

        // Reset mid-DATA after beat 2 of len=5, with prio left at 1 beforehand.
        start(0, 12'h300, 8'd5, 8'h66);
        for (int b = 0; b < 2; b++) begin
            set_beat(1'b1, 64'h300 + 64'(b), 8'h66, 1'b0);
            step();
        end
        axi_reset = 1'b1;
        set_ar(0, 1'b1, 12'h310, 8'd0, 8'h67);
        set_ar(1, 1'b1, 12'h320, 8'd0, 8'h68);
        #1;
        check("t5_rst_s0_ready", {63'd0, s0_if.ar_ready}, 64'd0);
        check("t5_rst_s1_ready", {63'd0, s1_if.ar_ready}, 64'd0);
        step();
        axi_reset = 1'b0;
        #1;
        check("t5_post_ar_valid", {63'd0, m_if.ar_valid}, 64'd0);
        check("t5_post_r_ready",  {63'd0, m_if.r_ready},  64'd0);
        check("t5_post_s0_rv",    {63'd0, s0_if.r_valid}, 64'd0);
        check("t5_post_prio_s0",  {63'd0, s0_if.ar_ready}, 64'd1);
        check("t5_post_prio_s1",  {63'd0, s1_if.ar_ready}, 64'd0);
        step();
        set_ar(0, 1'b0, 12'h000, 8'd0, 8'd0);
        set_ar(1, 1'b0, 12'h000, 8'd0, 8'd0);
        m_if.ar_ready = 1'b1;
        step();
        m_if.ar_ready = 1'b0;
        set_beat(1'b1, 64'h3FF, 8'h67, 1'b1);
        #1;
        check("t5_drain_s0_rv", {63'd0, s0_if.r_valid}, 64'd1);
        step();
        set_beat(1'b0, 64'd0, 8'd0, 1'b0);
        start(1, 12'h400, 8'd0, 8'h77);
        set_beat(1'b1, 64'h400, 8'h77, 1'b1);
        step();

        // Only s1 requesting with prio=0: grant every 3 cycles, no extra bubble.
        set_ar(1, 1'b1, 12'h500, 8'd0, 8'h5A);
        m_if.ar_ready = 1'b1;
        s1_if.r_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            check("t6_s1_ar_ready", {63'd0, s1_if.ar_ready}, (c % 3 == 0) ? 64'd1 : 64'd0);
            check("t6_m_ar_valid",  {63'd0, m_if.ar_valid},  (c % 3 == 1) ? 64'd1 : 64'd0);
            check("t6_m_r_ready",   {63'd0, m_if.r_ready},   (c % 3 == 2) ? 64'd1 : 64'd0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi_read_arbiter_2to1.md
# axi_read_arbiter_2to1

Two-master AXI read arbiter that shares the single read port of the on-chip AXI RAM (`axi_simple_dual_port_ram`) between two requesters. It grants one AR request at a time using round-robin priority and forwards the request downstream. It then routes the returning R beats to the granted master until the beat carrying RLAST has been accepted. Write channels are outside this block.

## Interface
- `AXI_ADDR_WIDTH`, 12, address width of all AR channels.
- `AXI_DATA_WIDTH`, 64, R data width.
- `AXI_ID_WIDTH`, 8, ID width; IDs pass through unmodified.
- `axi_clk`  in  1  sole clock; all logic is rising-edge.
- `axi_reset`  in  1  reset; **synchronous, active-high**.
- `sN_ar_addr` / `sN_ar_burst` / `sN_ar_size` / `sN_ar_id` / `sN_ar_len`  in  ADDR/2/3/ID/8  AR fields from master N, N∈{0,1}.
- `sN_ar_valid`  in  1  AR valid from master N.
- `sN_ar_ready`  out  1  AR ready to master N.
- `sN_r_data` / `sN_r_id` / `sN_r_resp` / `sN_r_last`  out  DATA/ID/2/1  R fields to master N.
- `sN_r_valid`  out  1  R valid to master N.
- `sN_r_ready`  in  1  R ready from master N.
- `m_ar_addr` / `m_ar_burst` / `m_ar_size` / `m_ar_id` / `m_ar_len`  out  ADDR/2/3/ID/8  registered AR fields to the RAM.
- `m_ar_valid`  out  1  AR valid to the RAM.
- `m_ar_ready`  in  1  AR ready from the RAM.
- `m_r_data` / `m_r_id` / `m_r_resp` / `m_r_last`  in  DATA/ID/2/1  R fields from the RAM.
- `m_r_valid`  in  1  R valid from the RAM.
- `m_r_ready`  out  1  R ready to the RAM.

## Operation
- **State machine:** IDLE → ADDR → DATA → IDLE. Register `sel` holds the granted master; register `prio` holds the master favoured on a tie.
- **IDLE:**
  - Grant rule: if exactly one `sN_ar_valid` is high, grant N. If both are high, grant `prio`.
  - On a grant, `sN_ar_ready`=1 for the granted master only, in the same cycle (combinational from state and valids). Upstream AR is therefore accepted whenever valid is seen in IDLE.
  - In that same cycle: latch the AR fields into the `m_ar_*` registers, set `sel`=N, go to ADDR.
  - If no valid is high: all `sN_ar_ready`=0 and the block stays in IDLE.
- **ADDR:**
  - `m_ar_valid`=1 with stable fields.
  - On `m_ar_valid && m_ar_ready`, go to DATA.
  - Both `sN_ar_ready`=0.
- **DATA:**
  - `m_r_ready` = `s<sel>_r_ready`.
  - `s<sel>_r_valid` = `m_r_valid`; `s<other>_r_valid`=0.
  - R fields fan out combinationally to both masters; only the selected master sees valid.
  - On `m_r_valid && m_r_ready && m_r_last`: go to IDLE and set `prio` = not `sel`.
- **Outside DATA:** `m_r_ready`=0 and both `sN_r_valid`=0. R beats arriving then are stalled, not dropped.
- **Pass-through and length:** burst, size, len and id pass through unchanged. The beat count is taken from `m_r_last` only; the block keeps no len counter.
- **Serialisation:** only one burst is outstanding at a time; a second AR is not accepted until the current burst's RLAST handshake completes.
- **Reset** (`axi_reset`=1 at a rising edge):
  - state=IDLE, `sel`=0, `prio`=0, `m_ar_valid`=0, all `m_ar_*` fields=0.
  - Combinational outputs follow: `sN_ar_ready`=0, `sN_r_valid`=0, `m_r_ready`=0 for the reset cycle. `sN_ar_ready` is forced 0 while reset is high.
  - Reset mid-ADDR or mid-DATA abandons the burst. The RAM shares `axi_clk` and is reset in the same cycle by the integrating top.

## Timing
- **AR latency:** AR accepted upstream in cycle T; `m_ar_valid` high from T+1.
- **Minimum burst cycle:** upstream accept to next possible accept = 2 + (cycles until RLAST handshake).
- **R path:** zero-latency combinational pass-through; no R buffering.
- **AXI stability:** `m_ar_valid` never drops before `m_ar_ready`; `m_ar_*` fields are constant while `m_ar_valid`=1.
- **Back-to-back:** an RLAST handshake in cycle T allows a new grant in T+1 (IDLE), with `m_ar_valid` from T+2.
- **Simultaneous requests:** grants alternate strictly when both masters request continuously. A master that loses waits at most one burst.

## Test plan
- **Single burst:** s0 AR addr=0x040, len=3, INCR, id=0x11 -> `m_ar_valid` the next cycle with identical fields; four R beats reach s0 with id 0x11 and last on beat 4; `s1_r_valid` stays 0.
- **Contention:** s0 and s1 both valid from reset, len=0, id=0xA0 and 0xB0 -> grant order s0, s1, s0, s1; `prio` toggles after each RLAST.
- **Backpressure:** s1 burst len=7 with `s1_r_ready` toggled every cycle -> `m_r_ready` mirrors it; exactly 8 beats are accepted, in order, with no loss.
- **AR stall:** `m_ar_ready` held low for 5 cycles -> `m_ar_valid`=1 and fields constant throughout; `sN_ar_ready`=0 for both masters until the burst ends.
- **Reset mid-DATA:** assert `axi_reset` after beat 2 of len=5 -> the next cycle shows IDLE, `m_ar_valid`=0, `prio`=0; a fresh s1 request is then granted normally.
- **Only s1 requesting:** s1 requests repeatedly while `prio`=0 -> s1 is granted each time, with no idle bubble beyond the 2-cycle minimum.
